// File: rtl/stochastic_pkg.sv
// Shared constants and FSM state encoding for the stochastic processor slice scheduler.
package stochastic_pkg;

   localparam int unsigned CT_MOD     = 1024;
   localparam int unsigned PT_MOD     = 256;
   localparam int unsigned STREAM_LEN = 1024;

   localparam int unsigned PT_W = $clog2(PT_MOD);
   localparam int unsigned CT_W = $clog2(CT_MOD);

   // Two full stream lengths is well beyond a healthy slice run.
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 2 * STREAM_LEN;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StRun,
      StSettle,
      StResp
   } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping around.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx
);

   logic        found;
   int unsigned idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/stochastic_slice_scheduler.sv
// Round-robin scheduler sharing one stochastic slice between NUM_REQ pixel requesters.
// Optional RUN watchdog with timeout_err output: define STOCH_SLICE_TIMEOUT_EN.
module stochastic_slice_scheduler
   import stochastic_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned ID_W          = 2,
   parameter int unsigned SETTLE_CYCLES = 2
`ifdef STOCH_SLICE_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*PT_W-1:0] req_byte1,
   input  logic [NUM_REQ*CT_W-1:0] req_key1,
   input  logic [NUM_REQ*PT_W-1:0] req_byte2,
   input  logic [NUM_REQ*CT_W-1:0] req_key2,
   output logic                   slice_start,
   output logic [PT_W-1:0]        slice_byte1,
   output logic [CT_W-1:0]        slice_key1,
   output logic [PT_W-1:0]        slice_byte2,
   output logic [CT_W-1:0]        slice_key2,
   input  logic                   slice_done,
   input  logic [PT_W-1:0]        slice_res,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PT_W-1:0]        out_data,
   output logic [ID_W-1:0]        out_id,
   output logic                   busy
`ifdef STOCH_SLICE_TIMEOUT_EN
   , output logic                 timeout_err
`endif
);

   sched_state_e state_q, state_d;

   logic [ID_W-1:0]    rr_ptr_q;
   logic [ID_W-1:0]    owner_q;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic               accept;
   logic               armed_q;
   logic [3:0]         settle_q;
   logic               done_seen;
   logic               timed_out;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign accept    = (state_q == StIdle) && (|req_valid);
   // A done level only counts once the slice has been seen low after this run's start.
   assign done_seen = slice_done && armed_q;

`ifdef STOCH_SLICE_TIMEOUT_EN
   localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TCNT_W-1:0] tcnt_q;
   logic              terr_q;
   assign timed_out   = (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err = terr_q;
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (accept) state_d = StStart;
         StStart:  state_d = StRun;
         StRun:    if (done_seen) state_d = StSettle;
                   else if (timed_out) state_d = StResp;
         StSettle: if (settle_q == 4'd0) state_d = StResp;
         StResp:   if (out_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready   = (state_q == StIdle) ? grant : '0;
      slice_start = (state_q == StStart);
      out_valid   = (state_q == StResp);
      busy        = (state_q != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         armed_q     <= 1'b0;
         settle_q    <= '0;
         slice_byte1 <= '0;
         slice_key1  <= '0;
         slice_byte2 <= '0;
         slice_key2  <= '0;
         out_data    <= '0;
         out_id      <= '0;
`ifdef STOCH_SLICE_TIMEOUT_EN
         tcnt_q      <= '0;
         terr_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  slice_byte1 <= req_byte1[grant_idx*PT_W +: PT_W];
                  slice_key1  <= req_key1[grant_idx*CT_W +: CT_W];
                  slice_byte2 <= req_byte2[grant_idx*PT_W +: PT_W];
                  slice_key2  <= req_key2[grant_idx*CT_W +: CT_W];
                  owner_q     <= grant_idx;
                  rr_ptr_q    <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
               end
            end
            StStart: begin
               armed_q <= 1'b0;
`ifdef STOCH_SLICE_TIMEOUT_EN
               tcnt_q  <= '0;
               terr_q  <= 1'b0;
`endif
            end
            StRun: begin
               if (!slice_done) armed_q <= 1'b1;
               if (done_seen) begin
                  settle_q <= 4'(SETTLE_CYCLES);
               end else if (timed_out) begin
                  out_data <= '0;
                  out_id   <= owner_q;
               end
`ifdef STOCH_SLICE_TIMEOUT_EN
               tcnt_q <= tcnt_q + 1'b1;
               if (!done_seen && timed_out) terr_q <= 1'b1;
`endif
            end
            StSettle: begin
               if (settle_q == 4'd0) begin
                  out_data <= slice_res;
                  out_id   <= owner_q;
               end else begin
                  settle_q <= settle_q - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stochastic_slice_scheduler.sv
// Self-checking bench for stochastic_slice_scheduler with a behavioural slice model.
module tb_stochastic_slice_scheduler;

   localparam int NR = 4;
   localparam int S  = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] req_valid;
   logic [NR-1:0] req_ready;
   logic [NR*8-1:0]  req_byte1, req_byte2;
   logic [NR*10-1:0] req_key1, req_key2;
   logic          slice_start;
   logic [7:0]    slice_byte1, slice_byte2;
   logic [9:0]    slice_key1, slice_key2;
   logic          slice_done;
   logic [7:0]    slice_res;
   logic          out_valid, out_ready;
   logic [7:0]    out_data;
   logic [1:0]    out_id;
   logic          busy;
`ifdef STOCH_SLICE_TIMEOUT_EN
   logic          timeout_err;
`endif

   logic [7:0] b1 [NR];
   logic [7:0] b2 [NR];
   logic [9:0] k1 [NR];
   logic [9:0] k2 [NR];

   for (genvar i = 0; i < NR; i++) begin : g_pack
      assign req_byte1[8*i +: 8]  = b1[i];
      assign req_byte2[8*i +: 8]  = b2[i];
      assign req_key1[10*i +: 10] = k1[i];
      assign req_key2[10*i +: 10] = k2[i];
   end

   stochastic_slice_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_byte1   (req_byte1),
      .req_key1    (req_key1),
      .req_byte2   (req_byte2),
      .req_key2    (req_key2),
      .slice_start (slice_start),
      .slice_byte1 (slice_byte1),
      .slice_key1  (slice_key1),
      .slice_byte2 (slice_byte2),
      .slice_key2  (slice_key2),
      .slice_done  (slice_done),
      .slice_res   (slice_res),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_id      (out_id),
      .busy        (busy)
`ifdef STOCH_SLICE_TIMEOUT_EN
      , .timeout_err (timeout_err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slice model: done high out of reset, dropped on start (optionally late), raised 1025 later.
   int         drop_delay = 0;
   int         drop_cnt   = 0;
   int         mdl_cnt    = 0;
   logic [7:0] sum_q      = 8'h00;
   initial begin
      slice_done = 1'b1;
      slice_res  = 8'h00;
   end
   always @(posedge clk) begin
      if (slice_start) begin
         mdl_cnt   <= 1025;
         sum_q     <= slice_byte1 + slice_byte2;
         slice_res <= 8'hEE;
         if (drop_delay == 0) slice_done <= 1'b0;
         else drop_cnt <= drop_delay;
      end else begin
         if (drop_cnt > 0) begin
            drop_cnt <= drop_cnt - 1;
            if (drop_cnt == 1) slice_done <= 1'b0;
         end
         if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) begin
               slice_done <= 1'b1;
               slice_res  <= sum_q;
            end
         end
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      int         id;
   } exp_t;

   exp_t       sb[$];
   int         got_ids[$];
   int         tb_ptr = 0;
   int         n_grant = 0, n_out = 0, n_start = 0;
   int         grant_cyc = 0, out_cyc = 0, out_at_grant = 0;
   int         last_id = 0;
   logic [7:0] last_data = 8'h00;
   logic [7:0] eb1 = 0, eb2 = 0;
   logic [9:0] ek1 = 0, ek2 = 0;
   logic       prev_start = 1'b0;

   function automatic int model_grant(input logic [NR-1:0] v, input int ptr);
      for (int k = 0; k < NR; k++) begin
         if (v[(ptr + k) % NR]) return (ptr + k) % NR;
      end
      return -1;
   endfunction

   // Monitor: predicts grants, pushes expected results, pops and compares on output handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         tb_ptr     = 0;
         prev_start = 1'b0;
      end else begin
         if (slice_start) begin
            n_start++;
            check("start_width", int'(prev_start), 0);
            check("op_byte1", int'(slice_byte1), int'(eb1));
            check("op_key1", int'(slice_key1), int'(ek1));
            check("op_byte2", int'(slice_byte2), int'(eb2));
            check("op_key2", int'(slice_key2), int'(ek2));
         end
         prev_start = slice_start;
         if (req_valid != 0 || req_ready != 0) begin
            int         g;
            logic [3:0] er;
            exp_t       e;
            g  = busy ? -1 : model_grant(req_valid, tb_ptr);
            er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            check("req_ready", int'(req_ready), int'(er));
            if (g >= 0) begin
               e.data = b1[g] + b2[g];
               e.id   = g;
               sb.push_back(e);
               eb1 = b1[g]; eb2 = b2[g]; ek1 = k1[g]; ek2 = k2[g];
               tb_ptr       = (g + 1) % NR;
               grant_cyc    = cyc;
               out_at_grant = n_out;
               n_grant++;
            end
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("out_data", int'(out_data), int'(e.data));
               check("out_id", int'(out_id), e.id);
            end
            last_data = out_data;
            last_id   = int'(out_id);
            got_ids.push_back(int'(out_id));
            out_cyc = cyc;
            n_out++;
         end
      end
   end

   task automatic wait_grant(input int target, input int budget);
      for (int c = 0; c < budget && n_grant < target; c++) begin
         @(posedge clk);
         #1;
      end
      if (n_grant < target) check("grant_timeout", n_grant, target);
   endtask

   task automatic wait_out(input int target, input int budget);
      for (int c = 0; c < budget && n_out < target; c++) begin
         @(posedge clk);
         #1;
      end
      if (n_out < target) check("out_timeout", n_out, target);
   endtask

   task automatic set_req(input int id, input logic [7:0] x, input logic [7:0] y);
      b1[id] = x;
      b2[id] = y;
      k1[id] = 10'(37 * id + x);
      k2[id] = 10'(1000 - y);
   endtask

   typedef struct {
      int         id;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[6];
   int   ord[5];

   initial begin
      int o;
      int bad;
      logic [7:0] d0;
      logic [1:0] i0;

      tbl[0] = '{id: 0, x: 8'd100, y: 8'd50,  exp: 8'd150};
      tbl[1] = '{id: 2, x: 8'd200, y: 8'd100, exp: 8'd44};
      tbl[2] = '{id: 1, x: 8'd255, y: 8'd1,   exp: 8'd0};
      tbl[3] = '{id: 3, x: 8'd0,   y: 8'd0,   exp: 8'd0};
      tbl[4] = '{id: 0, x: 8'd255, y: 8'd255, exp: 8'd254};
      tbl[5] = '{id: 2, x: 8'd17,  y: 8'd3,   exp: 8'd20};
      ord    = '{0, 1, 2, 3, 0};

      rst_n     = 1'b0;
      req_valid = '0;
      out_ready = 1'b1;
      for (int i = 0; i < NR; i++) set_req(i, 8'(10 * i + 1), 8'(3 * i + 7));
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_slice_start", int'(slice_start), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_id", int'(out_id), 0);
      check("rst_byte1", int'(slice_byte1), 0);
      check("rst_key2", int'(slice_key2), 0);

      // Contention: all four valid from reset release, five grants in rotation.
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = 4'hF;
      wait_grant(5, 6000);
      req_valid = '0;
      wait_out(5, 2000);
      check("rr_count", got_ids.size(), 5);
      for (int i = 0; i < 5 && i < got_ids.size(); i++) check("rr_order", got_ids[i], ord[i]);

      for (int i = 0; i < 6; i++) begin
         set_req(tbl[i].id, tbl[i].x, tbl[i].y);
         o = n_out;
         req_valid = 4'b0001 << tbl[i].id;
         wait_grant(n_grant + 1, 100);
         req_valid = '0;
         wait_out(o + 1, 1200);
         check("vec_data", int'(last_data), int'(tbl[i].exp));
         check("vec_id", last_id, tbl[i].id);
         check("vec_latency", out_cyc - grant_cyc, 1029 + S);
      end
      repeat (20) @(posedge clk);
      check("no_extra_start", n_start, n_grant);

      // Backpressure: result held 50 cycles while another requester waits.
      set_req(1, 8'd60, 8'd70);
      set_req(2, 8'd5, 8'd6);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      o = n_out;
      req_valid = 4'b0010;
      wait_grant(n_grant + 1, 100);
      req_valid = 4'b0100;
      bad = 0;
      for (int c = 0; c < 1200 && !out_valid; c++) @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      d0 = out_data;
      i0 = out_id;
      check("bp_data", int'(d0), 130);
      check("bp_id", int'(i0), 1);
      repeat (50) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_data !== d0 || out_id !== i0 || req_ready !== 4'b0000)
            bad++;
      end
      check("bp_stable", bad, 0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_grant(n_grant + 1, 100);
      req_valid = '0;
      check("bp_grant_after_hs", out_at_grant, o + 1);
      wait_out(o + 2, 1200);
      check("bp_next_data", int'(last_data), 11);
      check("bp_next_id", last_id, 2);

      // Stale done: the slice keeps done high for three cycles after start.
      drop_delay = 3;
      set_req(3, 8'd77, 8'd88);
      o = n_out;
      req_valid = 4'b1000;
      wait_grant(n_grant + 1, 100);
      req_valid = '0;
      wait_out(o + 1, 1200);
      check("stale_data", int'(last_data), 165);
      check("stale_latency", out_cyc - grant_cyc, 1029 + S);
      drop_delay = 0;

      // Reset in the middle of a run, then a normal request.
      set_req(0, 8'd9, 8'd9);
      o = n_out;
      req_valid = 4'b0001;
      wait_grant(n_grant + 1, 100);
      req_valid = '0;
      repeat (500) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_busy", int'(busy), 0);
      check("mrst_out_valid", int'(out_valid), 0);
      check("mrst_start", int'(slice_start), 0);
      check("mrst_byte1", int'(slice_byte1), 0);
      check("mrst_out_data", int'(out_data), 0);
      check("mrst_req_ready", int'(req_ready), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (1500) @(posedge clk);
      check("mrst_no_out", n_out, o);
      #1;
      set_req(2, 8'd128, 8'd64);
      req_valid = 4'b0100;
      wait_grant(n_grant + 1, 100);
      req_valid = '0;
      wait_out(o + 1, 1200);
      check("mrst_next_data", int'(last_data), 192);
      check("mrst_next_id", last_id, 2);
      check("start_count", n_start, n_grant);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
